spfs_rd_ctrl: RTL and testbench
===============================

Name: spfs_rd_ctrl

Overview:
Read-only sequencer for the custom single-bit SPI flash pins (cust_spfs clk/cs/mosi/miso). It accepts 24-bit byte-address word-read requests from the SoC-side bus and issues a flash READ (0x03), a 24-bit address and 32 data clocks. It returns the assembled 32-bit little-endian word. It sits between the custom peripheral bus bridge and the cust_spfs pads and is the only driver of those pads.

Parameters:
CLK_DIV, 2, sclk half-period in clk_i cycles (legal values 1..255)
CS_GAP, 4, minimum clk_i cycles cs_o stays high between transactions (legal values 1..255)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  1  read request valid
req_ready_o  out  1  controller can accept a request
req_addr_i  in  24  flash byte address
resp_valid_o  out  1  one-cycle pulse, resp_data_o valid
resp_data_o  out  32  read word; first received byte in [7:0]
busy_o  out  1  transaction or CS gap in progress
spfs_clk_o  out  1  SPI clock, mode 0
spfs_cs_o  out  1  chip select, active low
spfs_mosi_o  out  1  serial data to flash
spfs_miso_i  in  1  serial data from flash

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction) sets: state IDLE, spfs_cs_o=1, spfs_clk_o=0, spfs_mosi_o=0, resp_valid_o=0, resp_data_o=0, busy_o=0. req_ready_o=1 after reset. A transaction cut by reset is lost, and no response is issued for it.
- States: IDLE -> SHIFT -> DONE -> GAP -> IDLE.
- IDLE: req_ready_o=1. The handshake is req_valid_i&&req_ready_o at cycle T. On the handshake, latch the 64-bit shift word {8'h03, req_addr_i, 32'h0} and the address, then go to SHIFT. req_ready_o=0 in every other state, and busy_o=1 in every other state.
- SHIFT: spfs_cs_o=0 from T+1. spfs_mosi_o = shift MSB, valid from T+1.
- Divider counter runs 0..CLK_DIV-1. At each terminal count spfs_clk_o toggles.
  - First rising edge is at T+1+CLK_DIV.
  - Rising edge: sample spfs_miso_i into the RX shifter.
  - Falling edge: shift TX left and present the next bit on spfs_mosi_o.
- Bit counter 0..63. Bits 0..31 are command+address. miso samples taken on bits 32..63 form the data.
- After the 64th falling edge, spfs_clk_o=0 (cycle T+1+128*CLK_DIV), go to DONE.
- DONE (one cycle):
  - spfs_cs_o=1 and spfs_mosi_o=0.
  - resp_valid_o=1 for exactly this cycle, at T+2+128*CLK_DIV (T+258 with defaults).
  - resp_data_o = {byte3,byte2,byte1,byte0}, where byte0 is the first data byte received and each byte is MSB-first on the wire.
  - resp_data_o holds its value until the next DONE.
- No response backpressure: the requester must accept the pulse.
- GAP: spfs_cs_o stays high. Count CS_GAP-1 cycles, then go to IDLE. cs_o is therefore high for at least CS_GAP cycles before the next cs_o low.
- req_valid_i asserted while not IDLE is ignored. The requester holds the request; it is accepted on the first IDLE cycle. req_addr_i may change freely outside the handshake cycle.
- spfs_clk_o idles low. spfs_clk_o never toggles while spfs_cs_o=1.
- Address wrap is left to the flash; the controller does no range check.

Decomposition:
- Package spfs_pkg holds:
  - state enum {IDLE, SHIFT, DONE, GAP}
  - CMD_READ=8'h03
  - TOTAL_BITS=64
  - DATA_BITS=32
- One sub-module, spfs_sclk_div:
  - inputs: clk_i, rst_n_i, en, CLK_DIV
  - outputs: sclk, rise_stb, fall_stb
  - counter is cleared when en=0
- The shifters, bit counter and FSM live in spfs_rd_ctrl.

Test Plan:
- Basic read: flash model holds bytes EF,BE,AD,DE at 0x001234; request addr 0x001234 -> mosi bitstream 0x03001234; resp_data_o=0xDEADBEEF; resp_valid_o pulses exactly at T+258 (CLK_DIV=2).
- Back-to-back: req_valid_i held high with addrs 0x000000 then 0x000004 -> req_ready_o low until GAP ends; cs_o high for ≥4 cycles between transactions; two responses in order; no sclk edges while cs_o=1.
- CLK_DIV=1, CS_GAP=1: request at T -> resp_valid_o at T+130; sclk period = 2 clk_i cycles; data correct.
- Reset mid-transaction: assert rst_n_i=0 after 20 sclk edges -> same-cycle cs_o=1, clk_o=0, mosi_o=0; no resp_valid_o; next request after release completes normally.
- Busy ignore: pulse req_valid_i for one cycle during SHIFT -> no second transaction; busy_o=1 from T+1 until GAP exit; exactly one resp_valid_o.
- Addr boundary: addr 0xFFFFFC with model bytes 01,02,03,04 -> mosi 0x03FFFFFC, resp_data_o=0x04030201.

Source files
------------

// File: rtl/spfs_pkg.sv
// Shared types and constants for the single-bit SPI flash read sequencer.
package spfs_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_e;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         TOTAL_BITS = 64;
  localparam int         DATA_BITS  = 32;

  // Wire order is byte0 first, MSB-first per byte; the bus wants byte0 in [7:0].
  function automatic logic [DATA_BITS-1:0] wire_to_le(input logic [DATA_BITS-1:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spfs_sclk_div.sv
// SPI mode-0 clock divider: toggles sclk every CLK_DIV enabled cycles, idles low.
module spfs_sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] cnt_q;
  logic       term;

  assign term     = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise_stb = term && !sclk;
  assign fall_stb = term && sclk;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sclk  <= 1'b0;
    end else if (term) begin
      cnt_q <= '0;
      sclk  <= ~sclk;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spfs_rd_ctrl.sv
// Read-only SPI flash sequencer: READ cmd + 24-bit address, then 32 data clocks,
// returning a little-endian word. Sole driver of the cust_spfs pads.
module spfs_rd_ctrl
  import spfs_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        busy_o,
  output logic        spfs_clk_o,
  output logic        spfs_cs_o,
  output logic        spfs_mosi_o,
  input  logic        spfs_miso_i
);

  localparam int BCW = $clog2(TOTAL_BITS) + 1;

  state_e                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   tx_q;
  logic [DATA_BITS-1:0]    rx_q;
  logic [BCW-1:0]          bit_cnt_q;
  logic [7:0]              gap_cnt_q;
  logic                    sclk, rise_stb, fall_stb;
  logic                    hs, bits_done, div_en, gap_done;

  assign hs        = (state_q == IDLE) && req_valid_i;
  assign bits_done = (bit_cnt_q == BCW'(TOTAL_BITS));
  // Divider stops after the last falling edge so SHIFT holds one quiet cycle with sclk low.
  assign div_en    = (state_q == SHIFT) && !bits_done;
  // GAP lasts CS_GAP-1 cycles (at least one), so DONE+GAP keep cs high >= CS_GAP cycles.
  assign gap_done  = ({1'b0, gap_cnt_q} + 9'd2) >= 9'(CS_GAP);

  spfs_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en       (div_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = SHIFT;
      SHIFT:   if (bits_done) state_d = DONE;
      DONE:    state_d = GAP;
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      resp_data_o <= '0;
    end else begin
      state_q <= state_d;
      if (hs)            bit_cnt_q <= '0;
      else if (fall_stb) bit_cnt_q <= bit_cnt_q + BCW'(1);
      gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 8'd1 : 8'd0;
      if (state_q == SHIFT && bits_done) resp_data_o <= wire_to_le(rx_q);
    end
  end

  // Shift registers: TX loads on handshake and advances on falls, RX samples on rises.
  always_ff @(posedge clk_i) begin
    if (hs)            tx_q <= {CMD_READ, req_addr_i, {DATA_BITS{1'b0}}};
    else if (fall_stb) tx_q <= {tx_q[TOTAL_BITS-2:0], 1'b0};
    if (rise_stb)      rx_q <= {rx_q[DATA_BITS-2:0], spfs_miso_i};
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign spfs_cs_o    = (state_q != SHIFT);
  assign spfs_mosi_o  = (state_q == SHIFT) && tx_q[TOTAL_BITS-1];
  assign spfs_clk_o   = sclk;

endmodule

// File: tb/tb_spfs_rd_ctrl.sv
// Scoreboard bench for spfs_rd_ctrl: default instance plus a CLK_DIV=1/CS_GAP=1 instance,
// each attached to a behavioural SPI flash model.
module tb_spfs_rd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        rst0_n, req_valid0, req_ready0, resp_valid0, busy0, sclk0, cs0, mosi0;
  logic        miso0 = 1'b0;
  logic [23:0] req_addr0;
  logic [31:0] resp_data0;
  logic        rst1_n, req_valid1, req_ready1, resp_valid1, busy1, sclk1, cs1, mosi1;
  logic        miso1 = 1'b0;
  logic [23:0] req_addr1;
  logic [31:0] resp_data1;

  spfs_rd_ctrl #(.CLK_DIV(2), .CS_GAP(4)) dut0 (
    .clk_i(clk), .rst_n_i(rst0_n), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .req_addr_i(req_addr0), .resp_valid_o(resp_valid0), .resp_data_o(resp_data0),
    .busy_o(busy0), .spfs_clk_o(sclk0), .spfs_cs_o(cs0), .spfs_mosi_o(mosi0),
    .spfs_miso_i(miso0)
  );

  spfs_rd_ctrl #(.CLK_DIV(1), .CS_GAP(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst1_n), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_addr_i(req_addr1), .resp_valid_o(resp_valid1), .resp_data_o(resp_data1),
    .busy_o(busy1), .spfs_clk_o(sclk1), .spfs_cs_o(cs1), .spfs_mosi_o(mosi1),
    .spfs_miso_i(miso1)
  );

  // Flash contents
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h001234: return 8'hEF;
      24'h001235: return 8'hBE;
      24'h001236: return 8'hAD;
      24'h001237: return 8'hDE;
      24'hFFFFFC: return 8'h01;
      24'hFFFFFD: return 8'h02;
      24'hFFFFFE: return 8'h03;
      24'hFFFFFF: return 8'h04;
      default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
  endfunction

  function automatic logic data_bit(input logic [23:0] a, input int j);
    logic [7:0] b;
    b = fbyte(a + 24'(j / 8));
    return b[7 - (j % 8)];
  endfunction

  // Flash models: capture 32 mosi bits on rises, drive data on falls
  int bitn0 = 0, bitn1 = 0;
  logic [31:0] cmd0 = '0, cmd1 = '0;
  always @(negedge cs0) bitn0 = 0;
  always @(posedge sclk0) begin
    if (bitn0 < 32) cmd0 = {cmd0[30:0], mosi0};
    bitn0++;
  end
  always @(negedge sclk0) if (bitn0 >= 32 && bitn0 < 64) miso0 = data_bit(cmd0[23:0], bitn0 - 32);
  always @(negedge cs1) bitn1 = 0;
  always @(posedge sclk1) begin
    if (bitn1 < 32) cmd1 = {cmd1[30:0], mosi1};
    bitn1++;
  end
  always @(negedge sclk1) if (bitn1 >= 32 && bitn1 < 64) miso1 = data_bit(cmd1[23:0], bitn1 - 32);

  typedef struct {
    logic [31:0] data;
    logic [31:0] cmd;
    int          t;
  } exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  int resp0 = 0, resp1 = 0;
  int cs0_run = 0, cs1_run = 0, cs0_min = 100000, cs1_min = 100000, cs0_fall = 0;
  int sclk_viol0 = 0, sclk_viol1 = 0;

  always @(negedge clk) begin
    if (rst0_n && req_valid0 && req_ready0)
      q0.push_back('{data: exp_word(req_addr0), cmd: {8'h03, req_addr0}, t: cyc});
    if (resp_valid0) begin
      resp0++;
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp0_unexpected got=%h want=none", resp_data0);
      end else begin
        e0 = q0.pop_front();
        checks += 3;
        if (resp_data0 !== e0.data) begin
          failures++; $display("FAIL resp0_data got=%h want=%h", resp_data0, e0.data);
        end
        if (cmd0 !== e0.cmd) begin
          failures++; $display("FAIL resp0_mosi_cmd got=%h want=%h", cmd0, e0.cmd);
        end
        if (cyc - e0.t !== 258) begin
          failures++; $display("FAIL resp0_latency got=%0d want=258", cyc - e0.t);
        end
      end
    end
    if (cs0 && sclk0) sclk_viol0++;
    if (cs0) cs0_run++;
    else begin
      if (cs0_run > 0) begin
        cs0_fall++;
        if (cs0_run < cs0_min) cs0_min = cs0_run;
      end
      cs0_run = 0;
    end
  end

  always @(negedge clk) begin
    if (rst1_n && req_valid1 && req_ready1)
      q1.push_back('{data: exp_word(req_addr1), cmd: {8'h03, req_addr1}, t: cyc});
    if (resp_valid1) begin
      resp1++;
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL resp1_unexpected got=%h want=none", resp_data1);
      end else begin
        e1 = q1.pop_front();
        checks += 3;
        if (resp_data1 !== e1.data) begin
          failures++; $display("FAIL resp1_data got=%h want=%h", resp_data1, e1.data);
        end
        if (cmd1 !== e1.cmd) begin
          failures++; $display("FAIL resp1_mosi_cmd got=%h want=%h", cmd1, e1.cmd);
        end
        if (cyc - e1.t !== 130) begin
          failures++; $display("FAIL resp1_latency got=%0d want=130", cyc - e1.t);
        end
      end
    end
    if (cs1 && sclk1) sclk_viol1++;
    if (cs1) cs1_run++;
    else begin
      if (cs1_run > 0 && cs1_run < cs1_min) cs1_min = cs1_run;
      cs1_run = 0;
    end
  end

  task automatic issue(input int sel, input logic [23:0] a);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (sel == 0) begin req_valid0 = 1'b1; req_addr0 = a; end
    else begin req_valid1 = 1'b1; req_addr1 = a; end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((sel == 0) ? req_ready0 : req_ready1) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL issue_handshake sel=%0d got=no_ready want=ready", sel); end
    @(posedge clk); #1;
    if (sel == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
  endtask

  task automatic wait_resp(input int sel, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((sel == 0) ? resp0 : resp1) >= target) break;
    end
    @(negedge clk);
    checks++;
    if (((sel == 0) ? resp0 : resp1) < target) begin
      failures++;
      $display("FAIL resp_timeout sel=%0d got=%0d want=%0d", sel, (sel == 0) ? resp0 : resp1, target);
    end
  endtask

  task automatic test_reset;
    rst0_n = 1'b0; rst1_n = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0; req_addr0 = '0; req_addr1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if ({cs0, sclk0, mosi0, resp_valid0, busy0, req_ready0} !== 6'b100001) begin
      failures++; $display("FAIL reset0_ctrl got=%b want=100001", {cs0, sclk0, mosi0, resp_valid0, busy0, req_ready0});
    end
    if (resp_data0 !== 32'h0) begin failures++; $display("FAIL reset0_data got=%h want=0", resp_data0); end
    if ({cs1, sclk1, mosi1, resp_valid1, busy1, req_ready1} !== 6'b100001) begin
      failures++; $display("FAIL reset1_ctrl got=%b want=100001", {cs1, sclk1, mosi1, resp_valid1, busy1, req_ready1});
    end
    if (resp_data1 !== 32'h0) begin failures++; $display("FAIL reset1_data got=%h want=0", resp_data1); end
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_basic_read;
    int r;
    r = resp0;
    issue(0, 24'h001234);
    wait_resp(0, r + 1, 600);
    checks += 2;
    if (resp_data0 !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got=%h want=deadbeef", resp_data0); end
    if (cmd0 !== 32'h03001234) begin failures++; $display("FAIL basic_mosi got=%h want=03001234", cmd0); end
  endtask

  task automatic test_back_to_back;
    int r, lowcnt;
    logic got;
    r = resp0; lowcnt = 0; got = 1'b0;
    @(posedge clk); #1;
    req_valid0 = 1'b1; req_addr0 = 24'h000000;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready0) break;
    end
    @(posedge clk); #1;
    req_addr0 = 24'h000004;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready0) begin got = 1'b1; break; end
      lowcnt++;
    end
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    checks++;
    if (!got || lowcnt !== 261) begin failures++; $display("FAIL b2b_ready_low got=%0d want=261", lowcnt); end
    wait_resp(0, r + 2, 1200);
    checks++;
    if (resp_data0 !== exp_word(24'h000004)) begin
      failures++; $display("FAIL b2b_second_data got=%h want=%h", resp_data0, exp_word(24'h000004));
    end
  endtask

  task automatic test_clkdiv1;
    int r, nrise, c0, c1;
    logic prev;
    r = resp1; nrise = 0; c0 = 0; c1 = 0;
    issue(1, 24'h001234);
    prev = sclk1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sclk1 && !prev) begin
        if (nrise == 0) c0 = cyc; else if (nrise == 1) c1 = cyc;
        nrise++;
      end
      prev = sclk1;
    end
    checks++;
    if (nrise < 2 || c1 - c0 !== 2) begin failures++; $display("FAIL div1_sclk_period got=%0d want=2", c1 - c0); end
    wait_resp(1, r + 1, 400);
    checks++;
    if (resp_data1 !== 32'hDEADBEEF) begin failures++; $display("FAIL div1_data got=%h want=deadbeef", resp_data1); end
  endtask

  task automatic test_reset_mid;
    int r, edges;
    logic prev;
    r = resp0; edges = 0;
    issue(0, 24'h000100);
    prev = sclk0;
    for (int i = 0; i < 400 && edges < 20; i++) begin
      @(negedge clk);
      if (sclk0 !== prev) begin edges++; prev = sclk0; end
    end
    #2 rst0_n = 1'b0;
    #1;
    checks += 2;
    if (edges < 20) begin failures++; $display("FAIL rstmid_edges got=%0d want=20", edges); end
    if ({cs0, sclk0, mosi0, resp_valid0, busy0, req_ready0} !== 6'b100001) begin
      failures++; $display("FAIL rstmid_pins got=%b want=100001", {cs0, sclk0, mosi0, resp_valid0, busy0, req_ready0});
    end
    q0.delete();
    repeat (5) @(posedge clk);
    #1 rst0_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (resp0 !== r) begin failures++; $display("FAIL rstmid_no_resp got=%0d want=%0d", resp0, r); end
    issue(0, 24'h001234);
    wait_resp(0, r + 1, 600);
    checks++;
    if (resp_data0 !== 32'hDEADBEEF) begin failures++; $display("FAIL rstmid_after_data got=%h want=deadbeef", resp_data0); end
  endtask

  task automatic test_busy_ignore;
    int r, f, bad;
    r = resp0; f = cs0_fall; bad = 0;
    issue(0, 24'h00ABC0);
    for (int i = 0; i < 261; i++) begin
      @(negedge clk);
      if (busy0 !== 1'b1) bad++;
      if (i == 50) begin req_valid0 = 1'b1; req_addr0 = 24'h000777; end
      if (i == 51) req_valid0 = 1'b0;
    end
    @(negedge clk);
    checks += 2;
    if (bad !== 0) begin failures++; $display("FAIL busy_held got=%0d_low_cycles want=0", bad); end
    if ({busy0, req_ready0} !== 2'b01) begin failures++; $display("FAIL busy_gap_exit got=%b want=01", {busy0, req_ready0}); end
    repeat (300) @(negedge clk);
    checks += 2;
    if (resp0 !== r + 1) begin failures++; $display("FAIL busy_one_resp got=%0d want=%0d", resp0, r + 1); end
    if (cs0_fall !== f + 1) begin failures++; $display("FAIL busy_one_txn got=%0d want=%0d", cs0_fall, f + 1); end
  endtask

  task automatic test_addr_boundary;
    int r;
    r = resp0;
    issue(0, 24'hFFFFFC);
    wait_resp(0, r + 1, 600);
    checks += 2;
    if (resp_data0 !== 32'h04030201) begin failures++; $display("FAIL bound_data got=%h want=04030201", resp_data0); end
    if (cmd0 !== 32'h03FFFFFC) begin failures++; $display("FAIL bound_mosi got=%h want=03fffffc", cmd0); end
  endtask

  task automatic test_cs_rules;
    checks += 6;
    if (sclk_viol0 !== 0) begin failures++; $display("FAIL sclk0_while_cs_high got=%0d want=0", sclk_viol0); end
    if (sclk_viol1 !== 0) begin failures++; $display("FAIL sclk1_while_cs_high got=%0d want=0", sclk_viol1); end
    if (cs0_min < 4) begin failures++; $display("FAIL cs0_gap got=%0d want>=4", cs0_min); end
    if (cs1_min < 1) begin failures++; $display("FAIL cs1_gap got=%0d want>=1", cs1_min); end
    if (q0.size() !== 0) begin failures++; $display("FAIL q0_pending got=%0d want=0", q0.size()); end
    if (q1.size() !== 0) begin failures++; $display("FAIL q1_pending got=%0d want=0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_clkdiv1();
    test_reset_mid();
    test_busy_ignore();
    test_addr_boundary();
    test_cs_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
